// File: rtl/seq_addsub16_pkg.sv
// Shared widths and controller state encodings for the nibble-serial add/subtract unit.
package seq_addsub16_pkg;

  localparam int WORD_W  = 16;
  localparam int NIB_W   = 4;
  localparam int N_STEPS = 4;
  localparam int CNT_W   = 2;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_addsub16_nibble_adder_c.sv
// 4-bit ripple adder exposing both the carry into bit 3 and the carry out,
// so the caller can derive signed overflow on the top nibble.
module nibble_adder_c
  import seq_addsub16_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c3
);

  logic [3:0] low_sum;
  logic [1:0] top_sum;

  // Split at bit 3 so the internal carry is observable without a second adder.
  assign low_sum = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
  assign c3      = low_sum[3];
  assign top_sum = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
  assign s       = {top_sum[0], low_sum[2:0]};
  assign cout    = top_sum[1];

endmodule

// File: rtl/seq_addsub16.sv
// 16-bit add/subtract computed over four cycles through one shared nibble adder,
// least significant nibble first.
module seq_addsub16
  import seq_addsub16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              is_sub,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] sum,
  output logic              ovfl
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                carry_q;
  logic                sub_q;
  logic                ovfl_q;
  logic [WORD_W-1:0]   a_q, b_q, sum_q;
  logic                accept;

  logic [NIB_W-1:0]    a_nibs [N_STEPS];
  logic [NIB_W-1:0]    b_nibs [N_STEPS];
  logic [NIB_W-1:0]    add_a, add_b, add_s;
  logic                add_cout, add_c3;

  genvar gi;
  generate
    for (gi = 0; gi < N_STEPS; gi++) begin : g_nib
      assign a_nibs[gi] = a_q[gi*NIB_W +: NIB_W];
      assign b_nibs[gi] = b_q[gi*NIB_W +: NIB_W];
    end
  endgenerate

  // Subtraction is A + ~B + 1; the +1 comes from the carry preset at accept.
  assign add_a = a_nibs[cnt_q];
  assign add_b = b_nibs[cnt_q] ^ {NIB_W{sub_q}};

  nibble_adder_c u_nib (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout),
    .c3   (add_c3)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_STEP) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      ovfl_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= is_sub;
        cnt_q   <= '0;
        carry_q <= is_sub;
        sum_q   <= '0;
      end else if (state_q == ST_RUN) begin
        sum_q[cnt_q*NIB_W +: NIB_W] <= add_s;
        carry_q <= add_cout;
        cnt_q   <= cnt_q + 1'b1;
        // On the top nibble, c3 is the carry into bit 15; carry out of 15 is dropped.
        if (cnt_q == LAST_STEP) ovfl_q <= add_c3 ^ add_cout;
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign ovfl = ovfl_q;

endmodule

// File: tb/tb_seq_addsub16.sv
// Randomized and directed checks of seq_addsub16 against a signed-arithmetic reference model.
module tb_seq_addsub16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        is_sub;
  logic        busy, done;
  logic [15:0] sum;
  logic        ovfl;

  int n_vec  = 0;
  int n_miss = 0;

  seq_addsub16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .is_sub (is_sub),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .ovfl   (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer result, then wrap to 16 bits; overflow when out of signed range.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                                output logic [15:0] s, output logic o);
    int sa, sb, r;
    sa = $signed(av);
    sb = $signed(bv);
    r  = sv ? (sa - sb) : (sa + sb);
    s  = r[15:0];
    o  = (r > 32767) || (r < -32768);
  endfunction

  // Stimulus helper (no checking): called at a negedge, returns at the negedge where done is seen.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       output int lat, output int busy_n, output logic [15:0] s, output logic o);
    start  = 1'b1;
    a      = av;
    b      = bv;
    is_sub = sv;
    @(negedge clk);
    start  = 1'b0;
    a      = 16'($urandom);
    b      = 16'($urandom);
    is_sub = 1'($urandom);
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    s = sum;
    o = ovfl;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 16'hA5A5;
    b      = 16'h5A5A;
    is_sub = 1'b0;
    #3;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (sum !== 16'h0000) begin n_miss++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_vec++; if (ovfl !== 1'b0) begin n_miss++; $display("FAIL reset_ovfl: got %b want 0", ovfl); end
    $display("reset: busy=%b done=%b sum=%h ovfl=%b", busy, done, sum, ovfl);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] dir_a   [6] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h0005, 16'hFFFF, 16'h8000};
  logic [15:0] dir_b   [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0009, 16'h0001, 16'h7FFF};
  logic        dir_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] dir_sum [6] = '{16'h2233, 16'h8000, 16'h7FFF, 16'hFFFC, 16'h0000, 16'h0001};
  logic        dir_ov  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  // First op issued on the same negedge reset was released.
  task automatic test_directed();
    int lat, bn;
    logic [15:0] s;
    logic o;
    for (int i = 0; i < 6; i++) begin
      do_op(dir_a[i], dir_b[i], dir_sub[i], lat, bn, s, o);
      $display("dir[%0d]: a=%h b=%h sub=%b -> sum=%h ovfl=%b lat=%0d", i, dir_a[i], dir_b[i], dir_sub[i], s, o, lat);
      n_vec++; if (lat != 5) begin n_miss++; $display("FAIL dir_lat[%0d]: got %0d want 5", i, lat); end
      n_vec++; if (bn != 4) begin n_miss++; $display("FAIL dir_busy[%0d]: got %0d busy cycles want 4", i, bn); end
      n_vec++; if (s !== dir_sum[i]) begin n_miss++; $display("FAIL dir_sum[%0d]: got %h want %h", i, s, dir_sum[i]); end
      n_vec++; if (o !== dir_ov[i]) begin n_miss++; $display("FAIL dir_ovfl[%0d]: got %b want %b", i, o, dir_ov[i]); end
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL hold_done: got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL hold_busy: got %b want 0", busy); end
    n_vec++; if (sum !== 16'h0001) begin n_miss++; $display("FAIL hold_sum: got %h want 0001", sum); end
    n_vec++; if (ovfl !== 1'b1) begin n_miss++; $display("FAIL hold_ovfl: got %b want 1", ovfl); end
    $display("hold: done=%b busy=%b sum=%h ovfl=%b", done, busy, sum, ovfl);
  endtask

  task automatic test_random();
    int lat, bn;
    logic [15:0] av, bv, s, es;
    logic sv, o, eo;
    for (int i = 0; i < 40; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      sv = 1'($urandom);
      if ($urandom_range(0, 3) == 0) av = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 3) == 0) bv = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001;
      model(av, bv, sv, es, eo);
      do_op(av, bv, sv, lat, bn, s, o);
      $display("rnd[%0d]: a=%h b=%h sub=%b -> sum=%h ovfl=%b lat=%0d", i, av, bv, sv, s, o, lat);
      n_vec++; if (lat != 5) begin n_miss++; $display("FAIL rnd_lat[%0d]: got %0d want 5", i, lat); end
      n_vec++; if (s !== es) begin n_miss++; $display("FAIL rnd_sum[%0d]: got %h want %h", i, s, es); end
      n_vec++; if (o !== eo) begin n_miss++; $display("FAIL rnd_ovfl[%0d]: got %b want %b", i, o, eo); end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_s [$];
    logic        exp_o [$];
    logic [15:0] es, ws;
    logic        eo, wo;
    int issued, completed, gap, cyc;
    @(negedge clk);
    start  = 1'b1;
    a      = 16'($urandom);
    b      = 16'($urandom);
    is_sub = 1'($urandom);
    model(a, b, is_sub, es, eo);
    exp_s.push_back(es);
    exp_o.push_back(eo);
    issued = 1; completed = 0; gap = 0; cyc = 0;
    while (completed < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      gap++;
      if (done) begin
        ws = exp_s.pop_front();
        wo = exp_o.pop_front();
        $display("b2b[%0d]: sum=%h ovfl=%b gap=%0d", completed, sum, ovfl, gap);
        n_vec++; if (gap != 5) begin n_miss++; $display("FAIL b2b_gap[%0d]: got %0d want 5", completed, gap); end
        n_vec++; if (sum !== ws) begin n_miss++; $display("FAIL b2b_sum[%0d]: got %h want %h", completed, sum, ws); end
        n_vec++; if (ovfl !== wo) begin n_miss++; $display("FAIL b2b_ovfl[%0d]: got %b want %b", completed, ovfl, wo); end
        completed++;
        gap = 0;
        if (issued < 6) begin
          a      = 16'($urandom);
          b      = 16'($urandom);
          is_sub = 1'($urandom);
          model(a, b, is_sub, es, eo);
          exp_s.push_back(es);
          exp_o.push_back(eo);
          issued++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_vec++; if (completed != 6) begin n_miss++; $display("FAIL b2b_timeout: got %0d results want 6", completed); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [15:0] es, s0;
    logic eo;
    int lat, extra;
    model(16'h4321, 16'h1111, 1'b1, es, eo);
    start = 1'b1; a = 16'h4321; b = 16'h1111; is_sub = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    @(negedge clk);
    lat++;
    start = 1'b1; a = 16'hFFFF; b = 16'h7FFF; is_sub = 1'b0;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s0 = sum;
    $display("ignore: sum=%h ovfl=%b lat=%0d", sum, ovfl, lat);
    n_vec++; if (lat != 5) begin n_miss++; $display("FAIL ign_lat: got %0d want 5", lat); end
    n_vec++; if (sum !== es) begin n_miss++; $display("FAIL ign_sum: got %h want %h", sum, es); end
    n_vec++; if (ovfl !== eo) begin n_miss++; $display("FAIL ign_ovfl: got %b want %b", ovfl, eo); end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy || sum !== s0) extra++;
    end
    n_vec++; if (extra != 0) begin n_miss++; $display("FAIL ign_extra: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bn, dn;
    logic [15:0] s;
    logic o;
    do_op(16'h7FFF, 16'h0001, 1'b0, lat, bn, s, o);
    n_vec++; if (o !== 1'b1) begin n_miss++; $display("FAIL rmo_pre_ovfl: got %b want 1", o); end
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; is_sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("rst_mid: busy=%b done=%b sum=%h ovfl=%b", busy, done, sum, ovfl);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rmo_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL rmo_done: got %b want 0", done); end
    n_vec++; if (sum !== 16'h0000) begin n_miss++; $display("FAIL rmo_sum: got %h want 0000", sum); end
    n_vec++; if (ovfl !== 1'b0) begin n_miss++; $display("FAIL rmo_ovfl: got %b want 0", ovfl); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_vec++; if (dn != 0) begin n_miss++; $display("FAIL rmo_late_done: got %0d pulses want 0", dn); end
    do_op(16'h0005, 16'h0009, 1'b1, lat, bn, s, o);
    $display("rst_after: sum=%h ovfl=%b lat=%0d", s, o, lat);
    n_vec++; if (lat != 5) begin n_miss++; $display("FAIL rmo_lat: got %0d want 5", lat); end
    n_vec++; if (s !== 16'hFFFC) begin n_miss++; $display("FAIL rmo_sum_after: got %h want fffc", s); end
    n_vec++; if (o !== 1'b0) begin n_miss++; $display("FAIL rmo_ovfl_after: got %b want 0", o); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
